// File: rtl/arc4_pkg.sv
// Shared types, sizes and key-byte helper for the ARC4 ciphertext writer.
package arc4_pkg;

    localparam int          S_SIZE    = 256;
    localparam int          KEY_BYTES = 3;
    localparam int          KEY_BITS  = 8 * KEY_BYTES;
    localparam logic [7:0]  LAST_IDX  = 8'(S_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KSA,
        ST_LEN_RD,
        ST_LEN_WAIT,
        ST_LEN_WR,
        ST_P_RD_I,
        ST_P_WAIT_I,
        ST_P_RD_J,
        ST_P_WAIT_J,
        ST_P_WR_I,
        ST_P_WR_J,
        ST_P_RD_PAD,
        ST_P_WAIT_PAD,
        ST_P_WR_CT,
        ST_DONE
    } wr_state_e;

    typedef enum logic [2:0] {
        KS_IDLE,
        KS_INIT,
        KS_RD_I,
        KS_WAIT_I,
        KS_RD_J,
        KS_WAIT_J,
        KS_WR_I,
        KS_WR_J
    } ksa_state_e;

    // Key bytes are taken big-endian: index 0 is the most significant byte.
    function automatic logic [7:0] keybyte(input logic [KEY_BITS-1:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    keybyte = key[KEY_BITS-1  -: 8];
            2'd1:    keybyte = key[KEY_BITS-9  -: 8];
            2'd2:    keybyte = key[KEY_BITS-17 -: 8];
            default: keybyte = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/arc4_ksa_seq.sv
// INIT (S[i]=i) and ARC4 key schedule sequencer. Emits next-cycle S-port requests;
// the owner registers them and grants the port for the whole run.
module arc4_ksa_seq
    import arc4_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                grant_i,
    input  logic [KEY_BITS-1:0] key_i,
    input  logic [7:0]          s_rddata_i,
    output logic [7:0]          s_addr_o,
    output logic [7:0]          s_wrdata_o,
    output logic                s_wren_o,
    output logic                done_o
);

    ksa_state_e state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [1:0] kidx_q, kidx_d;
    logic [7:0] j_next_s;

    assign j_next_s = j_q + s_rddata_i + keybyte(key_i, kidx_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the sequencer freezes whenever the port is not granted
    always_comb begin
        state_d = state_q;
        if (state_q == KS_IDLE) begin
            state_d = start_i ? KS_INIT : KS_IDLE;
        end else if (grant_i) begin
            case (state_q)
                KS_INIT:   state_d = (i_q == LAST_IDX) ? KS_RD_I : KS_INIT;
                KS_RD_I:   state_d = KS_WAIT_I;
                KS_WAIT_I: state_d = KS_RD_J;
                KS_RD_J:   state_d = KS_WAIT_J;
                KS_WAIT_J: state_d = KS_WR_I;
                KS_WR_I:   state_d = KS_WR_J;
                KS_WR_J:   state_d = (i_q == LAST_IDX) ? KS_IDLE : KS_RD_I;
                default:   state_d = KS_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Port requests and datapath next values
    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        kidx_d     = kidx_q;
        s_addr_o   = 8'd0;
        s_wrdata_o = 8'd0;
        s_wren_o   = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (start_i) begin
                    i_d    = 8'd0;
                    j_d    = 8'd0;
                    kidx_d = 2'd0;
                end else begin
                    i_d    = i_q;
                end
            end
            KS_INIT: begin
                s_addr_o   = i_q;
                s_wrdata_o = i_q;
                s_wren_o   = grant_i;
                i_d        = grant_i ? (i_q + 8'd1) : i_q;
            end
            KS_RD_I: begin
                s_addr_o = i_q;
            end
            KS_RD_J: begin
                s_addr_o = j_next_s;
                if (grant_i) begin
                    si_d = s_rddata_i;
                    j_d  = j_next_s;
                end else begin
                    si_d = si_q;
                end
            end
            KS_WR_I: begin
                s_addr_o   = i_q;
                s_wrdata_o = s_rddata_i;
                s_wren_o   = grant_i;
            end
            KS_WR_J: begin
                s_addr_o   = j_q;
                s_wrdata_o = si_q;
                s_wren_o   = grant_i;
                if (grant_i) begin
                    i_d    = i_q + 8'd1;
                    kidx_d = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : (kidx_q + 2'd1);
                    done_o = (i_q == LAST_IDX);
                end else begin
                    i_d    = i_q;
                end
            end
            default: begin
                s_wren_o = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q    <= 8'd0;
            j_q    <= 8'd0;
            si_q   <= 8'd0;
            kidx_q <= 2'd0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            si_q   <= si_d;
            kidx_q <= kidx_d;
        end
    end

endmodule

// File: rtl/arc4_ct_writer.sv
// ARC4-encrypts a length-prefixed PT buffer into CT. Optional CT_CHECKSUM_EN adds ct_sum,
// the XOR of every byte written to CT.
module arc4_ct_writer
    import arc4_pkg::*;
#(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    input  logic [7:0]        s_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [7:0]        pt_rddata,
    output logic [ADDR_W-1:0] ct_addr,
    output logic [7:0]        ct_wrdata,
    output logic              ct_wren
`ifdef CT_CHECKSUM_EN
    ,
    output logic [7:0]        ct_sum
`endif
);

    wr_state_e         state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [7:0]        len_q, len_d, i_q, i_d, j_q, j_d;
    logic [7:0]        si_q, si_d, sj_q, sj_d, k_q, k_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d, pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d;
    logic [7:0]        s_wrdata_q, s_wrdata_d, ct_wrdata_q, ct_wrdata_d;
    logic              s_wren_q, s_wren_d, ct_wren_q, ct_wren_d, rdy_q, rdy_d;
    logic              accept_s, ksa_grant_s, ksa_done_s, ksa_wren_s;
    logic [7:0]        ksa_addr_s, ksa_wrdata_s, j_next_s, pad_addr_s;

    assign accept_s    = en && rdy_q;
    assign ksa_grant_s = (state_q == ST_KSA);
    assign j_next_s    = j_q + s_rddata;
    assign pad_addr_s  = si_q + sj_q;

    arc4_ksa_seq u_ksa (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept_s),
        .grant_i    (ksa_grant_s),
        .key_i      (key_q),
        .s_rddata_i (s_rddata),
        .s_addr_o   (ksa_addr_s),
        .s_wrdata_o (ksa_wrdata_s),
        .s_wren_o   (ksa_wren_s),
        .done_o     (ksa_done_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = accept_s ? ST_KSA : ST_IDLE;
            ST_KSA:        state_d = ksa_done_s ? ST_LEN_RD : ST_KSA;
            ST_LEN_RD:     state_d = ST_LEN_WAIT;
            ST_LEN_WAIT:   state_d = ST_LEN_WR;
            ST_LEN_WR:     state_d = (pt_rddata == 8'd0) ? ST_DONE : ST_P_RD_I;
            ST_P_RD_I:     state_d = ST_P_WAIT_I;
            ST_P_WAIT_I:   state_d = ST_P_RD_J;
            ST_P_RD_J:     state_d = ST_P_WAIT_J;
            ST_P_WAIT_J:   state_d = ST_P_WR_I;
            ST_P_WR_I:     state_d = ST_P_WR_J;
            ST_P_WR_J:     state_d = ST_P_RD_PAD;
            ST_P_RD_PAD:   state_d = ST_P_WAIT_PAD;
            ST_P_WAIT_PAD: state_d = ST_P_WR_CT;
            ST_P_WR_CT:    state_d = (k_q == len_q) ? ST_DONE : ST_P_RD_I;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered memory ports and PRGA datapath
    always_comb begin
        key_d       = key_q;
        len_d       = len_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        k_d         = k_q;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        s_wren_d    = 1'b0;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
        rdy_d       = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                key_d = accept_s ? key : key_q;
            end
            ST_KSA: begin
                s_addr_d   = ADDR_W'(ksa_addr_s);
                s_wrdata_d = ksa_wrdata_s;
                s_wren_d   = ksa_wren_s;
            end
            ST_LEN_RD: begin
                pt_addr_d = {ADDR_W{1'b0}};
            end
            ST_LEN_WR: begin
                len_d       = pt_rddata;
                ct_addr_d   = {ADDR_W{1'b0}};
                ct_wrdata_d = pt_rddata;
                ct_wren_d   = 1'b1;
                i_d         = 8'd0;
                j_d         = 8'd0;
                k_d         = 8'd1;
            end
            ST_P_RD_I: begin
                i_d      = i_q + 8'd1;
                s_addr_d = ADDR_W'(i_q + 8'd1);
            end
            ST_P_RD_J: begin
                si_d     = s_rddata;
                j_d      = j_next_s;
                s_addr_d = ADDR_W'(j_next_s);
            end
            ST_P_WR_I: begin
                sj_d       = s_rddata;
                s_addr_d   = ADDR_W'(i_q);
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
            end
            ST_P_WR_J: begin
                s_addr_d   = ADDR_W'(j_q);
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
            end
            // Pad lookup and the matching PT byte are fetched together
            ST_P_RD_PAD: begin
                s_addr_d  = ADDR_W'(pad_addr_s);
                pt_addr_d = ADDR_W'(k_q);
            end
            ST_P_WR_CT: begin
                ct_addr_d   = ADDR_W'(k_q);
                ct_wrdata_d = pt_rddata ^ s_rddata;
                ct_wren_d   = 1'b1;
                k_d         = k_q + 8'd1;
            end
            default: begin
                s_wren_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= {KEY_W{1'b0}};
            len_q       <= 8'd0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            k_q         <= 8'd0;
            s_addr_q    <= {ADDR_W{1'b0}};
            s_wrdata_q  <= 8'd0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= {ADDR_W{1'b0}};
            ct_addr_q   <= {ADDR_W{1'b0}};
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            key_q       <= key_d;
            len_q       <= len_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            k_q         <= k_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
            rdy_q       <= rdy_d;
        end
    end

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

`ifdef CT_CHECKSUM_EN
    logic [7:0] ct_sum_q, ct_sum_d;

    // Running XOR of every CT byte, cleared when a new run is accepted
    always_comb begin
        if (accept_s) begin
            ct_sum_d = 8'd0;
        end else if (ct_wren_d) begin
            ct_sum_d = ct_sum_q ^ ct_wrdata_d;
        end else begin
            ct_sum_d = ct_sum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_sum_q <= 8'd0;
        end else begin
            ct_sum_q <= ct_sum_d;
        end
    end

    assign ct_sum = ct_sum_q;
`endif

endmodule

// File: tb/tb_arc4_ct_writer.sv
// Self-checking bench for arc4_ct_writer: behavioural S/PT/CT memories and a software ARC4 model.
module tb_arc4_ct_writer;

    logic        clk = 1'b0;
    logic        rst_n, en, rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_wrdata, s_rddata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic        s_wren, ct_wren;
`ifdef CT_CHECKSUM_EN
    logic [7:0]  ct_sum;
`endif

    logic [7:0] s_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_img [256];
    logic [7:0] ct_img [256];
    logic [7:0] exp_ct [256];
    logic [7:0] exp_s [256];
    logic [7:0] dec [256];
    logic [7:0] dec_s [256];

    logic mem_clr = 1'b1;
    int   cur_len = 0;
    int   ct_wr_cnt, s_wr_cnt;
    logic ct_oob;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [23:0] key;
        int          len;
        int          kind;       // 0 zeros, 1 random, 2 "Plaintext", 3 0x41,0x42,...
        int          exp_ct_wr;  // expected ct_wren pulses
    } vec_t;
    vec_t vecs [8];

    arc4_ct_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .s_rddata  (s_rddata),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
`ifdef CT_CHECKSUM_EN
        ,
        .ct_sum    (ct_sum)
`endif
    );

    always #5 clk = ~clk;

    // Memories with 1-cycle read latency plus write monitors
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (mem_clr) begin
            ct_wr_cnt <= 0;
            s_wr_cnt  <= 0;
            ct_oob    <= 1'b0;
            for (int a = 0; a < 256; a++) ct_mem[a] <= 8'h5A;
        end else begin
            if (s_wren) begin
                s_mem[s_addr] <= s_wrdata;
                s_wr_cnt      <= s_wr_cnt + 1;
            end
            if (ct_wren) begin
                ct_mem[ct_addr] <= ct_wrdata;
                ct_wr_cnt       <= ct_wr_cnt + 1;
                if (int'(ct_addr) > cur_len) ct_oob <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Textbook ARC4: key schedule with a repeating 3-byte key, then keystream XOR
    task automatic arc4_model(input logic [23:0] k, input logic [7:0] src [256],
                              output logic [7:0] dst [256], output logic [7:0] sfin [256]);
        int sb [256];
        int i, j, t, n;
        n = int'(src[0]);
        for (int a = 0; a < 256; a++) sb[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + sb[a] + int'((k >> (8 * (2 - (a % 3)))) & 24'hFF)) % 256;
            t = sb[a]; sb[a] = sb[j]; sb[j] = t;
        end
        for (int a = 0; a < 256; a++) dst[a] = 8'h00;
        dst[0] = src[0];
        i = 0;
        j = 0;
        for (int m = 1; m <= n; m++) begin
            i = (i + 1) % 256;
            j = (j + sb[i]) % 256;
            t = sb[i]; sb[i] = sb[j]; sb[j] = t;
            dst[m] = src[m] ^ 8'(sb[(sb[i] + sb[j]) % 256]);
        end
        for (int a = 0; a < 256; a++) sfin[a] = 8'(sb[a]);
    endtask

    task automatic prep_op(input int len, input int kind);
        logic [71:0] txt;
        txt = "Plaintext";
        pt_mem[0] = 8'(len);
        for (int m = 1; m < 256; m++) begin
            case (kind)
                0:       pt_mem[m] = 8'h00;
                1:       pt_mem[m] = 8'($urandom);
                2:       pt_mem[m] = (m <= 9) ? txt[8*(9-m) +: 8] : 8'h00;
                default: pt_mem[m] = 8'(8'h40 + m);
            endcase
        end
        for (int m = 0; m < 256; m++) pt_img[m] = pt_mem[m];
        cur_len = len;
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
    endtask

    task automatic start_op(input logic [23:0] k);
        en  = 1'b1;
        key = k;
        @(negedge clk);
        en  = 1'b0;
        key = ~k;
        check("rdy_drop", {31'd0, rdy}, 32'd0);
    endtask

    task automatic wait_rdy();
        int cyc = 0;
        while (rdy !== 1'b1 && cyc < 12000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", {31'd0, rdy}, 32'd1);
    endtask

    task automatic verify_op(input logic [23:0] k, input int exp_wr);
        int bad, sbad, dbad;
        logic [7:0] xs;
        arc4_model(k, pt_img, exp_ct, exp_s);
        bad = 0;
        for (int m = 0; m <= cur_len; m++) if (ct_mem[m] !== exp_ct[m]) bad++;
        check("ct_bytes", bad, 0);
        check("ct_len_byte", {24'd0, ct_mem[0]}, cur_len);
        check("ct_wren_count", ct_wr_cnt, exp_wr);
        check("ct_out_of_range", {31'd0, ct_oob}, 32'd0);
        check("s_write_count", s_wr_cnt, 768 + 2 * cur_len);
        sbad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== exp_s[a]) sbad++;
        check("s_final_state", sbad, 0);
        for (int m = 0; m < 256; m++) ct_img[m] = ct_mem[m];
        arc4_model(k, ct_img, dec, dec_s);
        dbad = 0;
        for (int m = 0; m <= cur_len; m++) if (dec[m] !== pt_img[m]) dbad++;
        check("decrypt_roundtrip", dbad, 0);
        xs = 8'h00;
        for (int m = 0; m <= cur_len; m++) xs ^= exp_ct[m];
`ifdef CT_CHECKSUM_EN
        check("ct_sum", {24'd0, ct_sum}, {24'd0, xs});
`endif
    endtask

    initial begin
        logic [71:0] kat;
        int          kbad, l;
        kat   = 72'hBBF316E8D940AF0AD3;
        rst_n = 1'b0;
        en    = 1'b0;
        key   = 24'h000000;
        vecs[0] = '{24'h000000, 3,   0, 4};
        vecs[1] = '{24'h000000, 0,   0, 1};
        vecs[2] = '{24'h1E4600, 255, 1, 256};
        vecs[3] = '{24'h4B6579, 9,   2, 10};
        vecs[4] = '{24'hFFFFFF, 1,   1, 2};
        vecs[5] = '{24'hA1B2C3, 2,   3, 3};
        l = int'($urandom_range(2, 60));
        vecs[6] = '{24'($urandom), l, 1, l + 1};
        l = int'($urandom_range(100, 254));
        vecs[7] = '{24'($urandom), l, 1, l + 1};

        repeat (2) @(negedge clk);
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_wren", {30'd0, s_wren, ct_wren}, 32'd0);
        check("rst_addr", {8'd0, s_addr, pt_addr, ct_addr}, 32'd0);
        check("rst_data", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
`ifdef CT_CHECKSUM_EN
        check("rst_ct_sum", {24'd0, ct_sum}, 32'd0);
`endif
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);
        check("idle_rdy", {31'd0, rdy}, 32'd1);

        for (int v = 0; v < 8; v++) begin
            prep_op(vecs[v].len, vecs[v].kind);
            start_op(vecs[v].key);
            wait_rdy();
            verify_op(vecs[v].key, vecs[v].exp_ct_wr);
            if (vecs[v].kind == 2) begin
                kbad = 0;
                for (int m = 1; m <= 9; m++) if (ct_mem[m] !== kat[8*(9-m) +: 8]) kbad++;
                check("known_answer", kbad, 0);
            end
        end

        // A second en during the run must not restart it or reload the key
        prep_op(20, 1);
        start_op(24'hA5C3E1);
        repeat (48) @(negedge clk);
        en  = 1'b1;
        key = 24'h123456;
        @(negedge clk);
        en  = 1'b0;
        check("busy_rdy", {31'd0, rdy}, 32'd0);
        wait_rdy();
        verify_op(24'hA5C3E1, 21);

        // Reset in the middle of the key schedule, then a clean run
        prep_op(12, 1);
        start_op(24'h0F1E2D);
        repeat (298) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", {31'd0, rdy}, 32'd1);
        check("midrst_wren", {30'd0, s_wren, ct_wren}, 32'd0);
        @(negedge clk);
        check("midrst_rdy2", {31'd0, rdy}, 32'd1);
        check("midrst_wren2", {30'd0, s_wren, ct_wren}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_rdy", {31'd0, rdy}, 32'd1);
        prep_op(12, 1);
        start_op(24'h0F1E2D);
        wait_rdy();
        verify_op(24'h0F1E2D, 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
